event_encoder4to2: RTL and testbench

Sequential 4-to-2 priority encoder; the inverse of the team's 2-to-4 enable decoder.
- Captures up to four event request lines into sticky pending bits.
- Emits one 2-bit code per event through a valid/ready output stage.
- Serves interrupt-style or event-style sources that feed the decoder side of the design.

---
 rtl/enc_pkg.sv | 24 ++
 rtl/prio_pick4.sv | 48 ++++
 rtl/event_encoder4to2.sv | 94 +++++++++
 tb/tb_event_encoder4to2.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the event encoder slice: request/code widths,
// reset values for the held code and the rotate pointer, and a helper
// that turns an index into a one-hot request mask.
// ---------------------------------------------------------------------------
package enc_pkg;

  localparam int NUM_REQ = 4;
  localparam int CODE_W  = 2;

  localparam logic [CODE_W-1:0] CODE_RST = 2'b00;
  localparam logic [CODE_W-1:0] PTR_RST  = 2'b00;

  // One-hot mask with only bit k set; used to strip the loaded event out
  // of the pending pool.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [CODE_W-1:0] k);
    logic [NUM_REQ-1:0] mask;
    mask    = '0;
    mask[k] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/prio_pick4.sv
// ---------------------------------------------------------------------------
// prio_pick4
// Combinational 4-way picker.
//   pool [3:0] : candidate events
//   ptr  [1:0] : first index searched in rotating mode
//   rr         : 0 = fixed priority (highest index wins), 1 = rotating
//   any        : at least one candidate present
//   idx  [1:0] : index of the winning candidate (0 when any = 0)
// ---------------------------------------------------------------------------
module prio_pick4
  import enc_pkg::*;
(
  input  logic [NUM_REQ-1:0] pool,
  input  logic [CODE_W-1:0]  ptr,
  input  logic               rr,
  output logic               any,
  output logic [CODE_W-1:0]  idx
);

  logic               found;
  logic [CODE_W-1:0]  cand;

  // Fixed mode scans upward so the last hit (highest index) wins.
  // Rotating mode scans ptr, ptr+1, ... with natural 2-bit wrap and keeps
  // the first hit.
  always_comb begin
    any   = |pool;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    if (rr) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = ptr + CODE_W'(i);
        if (!found && pool[cand]) begin
          idx   = cand;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pool[i]) begin
          idx = CODE_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/event_encoder4to2.sv
// ---------------------------------------------------------------------------
// event_encoder4to2
// Sequential 4-to-2 priority encoder with sticky pending bits and a
// valid/ready output stage.
//   clk, rst_n     : clock, asynchronous active-low reset
//   en             : request capture enable
//   req [3:0]      : level-sampled event request lines
//   ready          : consumer accepts the presented code this cycle
//   clr_ovf        : clears the overflow flag (a new overflow wins)
//   code [1:0]     : index of the event being presented
//   valid          : code is valid
//   pending [3:0]  : captured events not yet loaded into the output stage
//   overflow       : sticky, set when a request hits an already-pending bit
// Parameter ROUND_ROBIN selects fixed (0) or rotating (1) priority.
// ---------------------------------------------------------------------------
module event_encoder4to2
  import enc_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ready,
  input  logic               clr_ovf,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  output logic [NUM_REQ-1:0] pending,
  output logic               overflow
);

  logic [NUM_REQ-1:0] req_en;
  logic [NUM_REQ-1:0] pool;
  logic [NUM_REQ-1:0] load;
  logic               slot_free;
  logic               any;
  logic [CODE_W-1:0]  idx;
  logic [CODE_W-1:0]  ptr;

  prio_pick4 u_pick (
    .pool (pool),
    .ptr  (ptr),
    .rr   (ROUND_ROBIN),
    .any  (any),
    .idx  (idx)
  );

  // The candidate pool is everything already pending plus this edge's
  // gated requests; the output slot can take a new code when empty or
  // when the current one is being accepted.
  always_comb begin
    req_en    = en ? req : '0;
    pool      = pending | req_en;
    slot_free = !valid || ready;
    load      = (slot_free && any) ? onehot(idx) : '0;
  end

  // All state. A request that lands on a bit that is already pending
  // collapses into it and raises overflow; a request matching the code
  // currently held is a fresh event because that code has already left
  // pending. The pointer only moves in rotating mode, so it stays at its
  // reset value in fixed mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code     <= CODE_RST;
      valid    <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
      ptr      <= PTR_RST;
    end else begin
      pending <= pool & ~load;

      if (|(req_en & pending)) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end

      if (slot_free) begin
        if (any) begin
          code  <= idx;
          valid <= 1'b1;
          if (ROUND_ROBIN) begin
            ptr <= idx + CODE_W'(1);
          end
        end else begin
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_event_encoder4to2.sv
// ---------------------------------------------------------------------------
// tb_event_encoder4to2
// Directed bench for event_encoder4to2. One fixed-priority and one
// rotating-priority instance share the same inputs; each sequence checks
// the instance it is about. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_event_encoder4to2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       ready;
  logic       clr_ovf;

  logic [1:0] fx_code;
  logic       fx_valid;
  logic [3:0] fx_pending;
  logic       fx_overflow;

  logic [1:0] rr_code;
  logic       rr_valid;
  logic [3:0] rr_pending;
  logic       rr_overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       ready;
    logic       clr_ovf;
    logic       exp_valid;
    logic [1:0] exp_code;
    logic [3:0] exp_pending;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  event_encoder4to2 #(.ROUND_ROBIN(1'b0)) dut_fx (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .ready    (ready),
    .clr_ovf  (clr_ovf),
    .code     (fx_code),
    .valid    (fx_valid),
    .pending  (fx_pending),
    .overflow (fx_overflow)
  );

  event_encoder4to2 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .ready    (ready),
    .clr_ovf  (clr_ovf),
    .code     (rr_code),
    .valid    (rr_valid),
    .pending  (rr_pending),
    .overflow (rr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then return 1 time unit after the
  // next rising edge so outputs can be sampled away from the edge.
  task automatic apply_stimulus(input logic e, input logic [3:0] r,
                                input logic rdy, input logic clr);
    @(negedge clk);
    en      = e;
    req     = r;
    ready   = rdy;
    clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [3:0] actual,
                              input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_fx(input string tag, input logic v, input logic [1:0] c,
                          input logic [3:0] p, input logic o);
    check_output({tag, " valid"},    {3'b0, fx_valid},    {3'b0, v});
    check_output({tag, " code"},     {2'b0, fx_code},     {2'b0, c});
    check_output({tag, " pending"},  fx_pending,          p);
    check_output({tag, " overflow"}, {3'b0, fx_overflow}, {3'b0, o});
  endtask

  initial begin
    logic [1:0] rr_exp [6];

    rst_n   = 1'b0;
    en      = 1'b0;
    req     = 4'b0000;
    ready   = 1'b0;
    clr_ovf = 1'b0;

    // en, req, ready, clr_ovf -> valid, code, pending, overflow
    // single event
    vecs.push_back('{1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'b10, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b10, 4'b0000, 1'b0});
    // fixed priority drain of 1011
    vecs.push_back('{1'b1, 4'b1011, 1'b1, 1'b0, 1'b1, 2'b11, 4'b0011, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0});
    // backpressure and overflow
    vecs.push_back('{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0010, 1'b1});
    vecs.push_back('{1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 2'b00, 4'b0010, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00, 4'b0010, 1'b0});
    // same index as the held code is a new event, not an overflow
    vecs.push_back('{1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0011, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0001, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0});
    // enable gating, then a one-cycle enable window
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 2'b11, 4'b0111, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 2'b10, 4'b0011, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0001, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_fx("reset", 1'b0, 2'b00, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sequences on the fixed-priority instance
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].en, vecs[i].req, vecs[i].ready, vecs[i].clr_ovf);
      check_fx($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
               vecs[i].exp_pending, vecs[i].exp_ovf);
    end

    // Asynchronous reset mid-cycle with a held code and pending events
    apply_stimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'b0110, 1'b0, 1'b0);
    check_fx("pre-reset", 1'b1, 2'b00, 4'b0110, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_fx("async reset", 1'b0, 2'b00, 4'b0000, 1'b0);
    en  = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Rotating priority with all requests held
    rr_exp = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 4'b1111, 1'b1, 1'b0);
      check_output($sformatf("rr%0d valid", i), {3'b0, rr_valid}, 4'b0001);
      check_output($sformatf("rr%0d code", i), {2'b0, rr_code}, {2'b0, rr_exp[i]});
      check_output($sformatf("rr%0d overflow", i), {3'b0, rr_overflow},
                   (i == 0) ? 4'b0000 : 4'b0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
